// File: rtl/sprite_comm_pkg.sv
// Shared handshake codes, FSM states and default field layout for the sprite table.
package sprite_comm_pkg;

   localparam logic [1:0] REQ_IDLE   = 2'b00;
   localparam logic [1:0] REQ_WRITE  = 2'b01;
   localparam logic [1:0] REQ_COMMIT = 2'b10;
   localparam logic [1:0] REQ_CLEAR  = 2'b11;

   localparam logic [1:0] RSP_READY = 2'b00;
   localparam logic [1:0] RSP_ACK   = 2'b01;
   localparam logic [1:0] RSP_PEND  = 2'b10;
   localparam logic [1:0] RSP_ERR   = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT_FRAME,
      ST_ACK,
      ST_ERR
   } comm_state_t;

   localparam int X_W_DEF     = 10;
   localparam int Y_W_DEF     = 10;
   localparam int STATE_W_DEF = 3;
   localparam int TYPE_W_DEF  = 3;

   // Entry packing, LSB upward: x, y, state, type.
   localparam int X_OFF     = 0;
   localparam int Y_OFF     = X_OFF + X_W_DEF;
   localparam int STATE_OFF = Y_OFF + Y_W_DEF;
   localparam int TYPE_OFF  = STATE_OFF + STATE_W_DEF;
   localparam int ENTRY_W_DEF = TYPE_OFF + TYPE_W_DEF;

endpackage

// File: rtl/sprite_table_comm_if.sv
// Software-side handshake bundle: request code, index and data in, response code out.
interface sprite_table_comm_if;
   logic [1:0]  to_hw_sig;
   logic [7:0]  sw_index;
   logic [31:0] sw_data;
   logic [1:0]  to_sw_sig;

   modport master (output to_hw_sig, output sw_index, output sw_data, input to_sw_sig);
   modport slave  (input to_hw_sig, input sw_index, input sw_data, output to_sw_sig);
endinterface

// File: rtl/sprite_entry_bank.sv
// Storage for one sprite entry. With SPRITE_TABLE_DOUBLE_BUFFER_EN a pending copy
// is written/cleared and moved to the active copy on commit; otherwise active is written directly.
module sprite_entry_bank #(
   parameter int ENTRY_W = 26
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               wr_en,
   input  logic               clr_en,
`ifdef SPRITE_TABLE_DOUBLE_BUFFER_EN
   input  logic               commit_en,
`endif
   input  logic [ENTRY_W-1:0] wr_data,
   output logic [ENTRY_W-1:0] active
);

`ifdef SPRITE_TABLE_DOUBLE_BUFFER_EN
   logic [ENTRY_W-1:0] pending;

   always_ff @(posedge clk) begin
      if (reset) begin
         pending <= '0;
         active  <= '0;
      end else begin
         if (clr_en)
            pending <= '0;
         else if (wr_en)
            pending <= wr_data;
         if (commit_en)
            active <= pending;
      end
   end
`else
   always_ff @(posedge clk) begin
      if (reset)
         active <= '0;
      else if (clr_en)
         active <= '0;
      else if (wr_en)
         active <= wr_data;
   end
`endif

endmodule

// File: rtl/sprite_table_comm.sv
// Sprite table fed by a four-phase software handshake; holds the FSM and index decode.
// SPRITE_TABLE_DOUBLE_BUFFER_EN selects frame-synchronous commit through a pending bank.
//
// state       | meaning
// ST_IDLE     | ready, decoding to_hw_sig
// ST_WAIT_FRAME| commit requested, waiting for frame_start
// ST_ACK      | request done, waiting for to_hw_sig = 00
// ST_ERR      | bad index, waiting for to_hw_sig = 00
module sprite_table_comm
   import sprite_comm_pkg::*;
#(
   parameter int NUM_SPRITES = 16,
   parameter int X_W         = X_W_DEF,
   parameter int Y_W         = Y_W_DEF,
   parameter int STATE_W     = STATE_W_DEF,
   parameter int TYPE_W      = TYPE_W_DEF
) (
   input  logic                           clk,
   input  logic                           reset,
   sprite_table_comm_if.slave             sw,
   input  logic                           frame_start,
   output logic [NUM_SPRITES*X_W-1:0]     sprite_x,
   output logic [NUM_SPRITES*Y_W-1:0]     sprite_y,
   output logic [NUM_SPRITES*STATE_W-1:0] sprite_state,
   output logic [NUM_SPRITES*TYPE_W-1:0]  sprite_type,
   output logic                           frame_commit
);

   localparam int Y_LSB   = X_W;
   localparam int S_LSB   = Y_LSB + Y_W;
   localparam int T_LSB   = S_LSB + STATE_W;
   localparam int ENTRY_W = T_LSB + TYPE_W;

   comm_state_t state, state_nxt;
   logic [1:0]  rsp_nxt;
   logic        commit_pulse_nxt;
   logic        wr_go, clr_go, idx_ok;
   logic        commit_go;

   assign idx_ok = {1'b0, sw.sw_index} < 9'(NUM_SPRITES);

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_IDLE;
         sw.to_sw_sig <= RSP_READY;
         frame_commit <= 1'b0;
      end else begin
         state        <= state_nxt;
         sw.to_sw_sig <= rsp_nxt;
         frame_commit <= commit_pulse_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            case (sw.to_hw_sig)
               REQ_WRITE:  state_nxt = idx_ok ? ST_ACK : ST_ERR;
`ifdef SPRITE_TABLE_DOUBLE_BUFFER_EN
               REQ_COMMIT: state_nxt = ST_WAIT_FRAME;
`else
               REQ_COMMIT: state_nxt = ST_ACK;
`endif
               REQ_CLEAR:  state_nxt = ST_ACK;
               default:    state_nxt = ST_IDLE;
            endcase
         end
`ifdef SPRITE_TABLE_DOUBLE_BUFFER_EN
         // A frame_start coinciding with the abort still wins: the request was live.
         ST_WAIT_FRAME: begin
            if (frame_start)
               state_nxt = ST_ACK;
            else if (sw.to_hw_sig == REQ_IDLE)
               state_nxt = ST_IDLE;
         end
`endif
         ST_ACK, ST_ERR: begin
            if (sw.to_hw_sig == REQ_IDLE)
               state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      wr_go     = (state == ST_IDLE) && (sw.to_hw_sig == REQ_WRITE) && idx_ok;
      clr_go    = (state == ST_IDLE) && (sw.to_hw_sig == REQ_CLEAR);
`ifdef SPRITE_TABLE_DOUBLE_BUFFER_EN
      commit_go = (state == ST_WAIT_FRAME) && frame_start;
      commit_pulse_nxt = commit_go;
`else
      commit_go = 1'b0;
      commit_pulse_nxt = wr_go || clr_go;
`endif
      case (state_nxt)
         ST_WAIT_FRAME: rsp_nxt = RSP_PEND;
         ST_ACK:        rsp_nxt = RSP_ACK;
         ST_ERR:        rsp_nxt = RSP_ERR;
         default:       rsp_nxt = RSP_READY;
      endcase
   end

`ifndef SPRITE_TABLE_DOUBLE_BUFFER_EN
   logic unused_single;
   assign unused_single = frame_start ^ commit_go;
`endif

   if (ENTRY_W < 32) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^sw.sw_data[31:ENTRY_W];
   end

   for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_entry
      logic [ENTRY_W-1:0] act;

      sprite_entry_bank #(.ENTRY_W(ENTRY_W)) u_bank (
         .clk       (clk),
         .reset     (reset),
         .wr_en     (wr_go && (sw.sw_index == 8'(i))),
         .clr_en    (clr_go),
`ifdef SPRITE_TABLE_DOUBLE_BUFFER_EN
         .commit_en (commit_go),
`endif
         .wr_data   (sw.sw_data[ENTRY_W-1:0]),
         .active    (act)
      );

      assign sprite_x[i*X_W +: X_W]             = act[X_W-1:0];
      assign sprite_y[i*Y_W +: Y_W]             = act[Y_LSB +: Y_W];
      assign sprite_state[i*STATE_W +: STATE_W] = act[S_LSB +: STATE_W];
      assign sprite_type[i*TYPE_W +: TYPE_W]    = act[T_LSB +: TYPE_W];
   end

endmodule

// File: tb/tb_sprite_table_comm.sv
// Directed bench for sprite_table_comm; expectations follow SPRITE_TABLE_DOUBLE_BUFFER_EN.
module tb_sprite_table_comm;
   import sprite_comm_pkg::*;

   localparam int NS = 16;
   localparam int XW = 10;
   localparam int YW = 10;
   localparam int SW = 3;
   localparam int TW = 3;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             frame_start = 1'b0;
   logic             frame_commit;
   logic [NS*XW-1:0] sprite_x;
   logic [NS*YW-1:0] sprite_y;
   logic [NS*SW-1:0] sprite_state;
   logic [NS*TW-1:0] sprite_type;

   sprite_table_comm_if sw_if ();

   sprite_table_comm #(
      .NUM_SPRITES(NS), .X_W(XW), .Y_W(YW), .STATE_W(SW), .TYPE_W(TW)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .sw           (sw_if),
      .frame_start  (frame_start),
      .sprite_x     (sprite_x),
      .sprite_y     (sprite_y),
      .sprite_state (sprite_state),
      .sprite_type  (sprite_type),
      .frame_commit (frame_commit)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   logic [31:0] act_m [NS];
`ifdef SPRITE_TABLE_DOUBLE_BUFFER_EN
   logic [31:0] pend_m [NS];
`endif

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] pk(input logic [9:0] x, input logic [9:0] y,
                                      input logic [2:0] s, input logic [2:0] t);
      return {6'b0, t, s, y, x};
   endfunction

   function automatic logic [31:0] ent(input int i);
      return {6'b0, sprite_type[i*TW +: TW], sprite_state[i*SW +: SW],
              sprite_y[i*YW +: YW], sprite_x[i*XW +: XW]};
   endfunction

   task automatic check_bank(input string tag);
      for (int i = 0; i < NS; i++)
         check($sformatf("%s_e%0d", tag, i), ent(i), act_m[i]);
   endtask

   task automatic drive(input logic [1:0] code, input logic [7:0] idx, input logic [31:0] data);
      sw_if.to_hw_sig = code;
      sw_if.sw_index  = idx;
      sw_if.sw_data   = data;
   endtask

   task automatic pulse_frame();
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
   endtask

   logic [31:0] e3, e15, e0;

   initial begin
      e3  = pk(10'h12C, 10'h0F0, 3'd2, 3'd5);
      e15 = pk(10'h3FF, 10'h001, 3'd7, 3'd1);
      e0  = pk(10'h155, 10'h2AA, 3'd3, 3'd6);
      for (int i = 0; i < NS; i++) begin
         act_m[i] = '0;
`ifdef SPRITE_TABLE_DOUBLE_BUFFER_EN
         pend_m[i] = '0;
`endif
      end
      drive(REQ_IDLE, 8'd0, 32'd0);
      repeat (3) @(negedge clk);
      check("rst_rsp", 32'(sw_if.to_sw_sig), 32'(RSP_READY));
      check("rst_fc", 32'(frame_commit), 32'd0);
      check_bank("rst");
      reset = 1'b0;
      @(negedge clk);

      // write entry 3, junk in the ignored upper bits
      drive(REQ_WRITE, 8'd3, 32'hFC00_0000 | e3);
      @(negedge clk);
`ifdef SPRITE_TABLE_DOUBLE_BUFFER_EN
      pend_m[3] = e3;
      check("wr_fc", 32'(frame_commit), 32'd0);
`else
      act_m[3] = e3;
      check("wr_fc", 32'(frame_commit), 32'd1);
`endif
      check("wr_rsp", 32'(sw_if.to_sw_sig), 32'(RSP_ACK));
      check("wr_e3", ent(3), act_m[3]);
      @(negedge clk);
      check("wr_hold_rsp", 32'(sw_if.to_sw_sig), 32'(RSP_ACK));
      check("wr_hold_fc", 32'(frame_commit), 32'd0);
      drive(REQ_IDLE, 8'd0, 32'd0);
      @(negedge clk);
      check("wr_rel", 32'(sw_if.to_sw_sig), 32'(RSP_READY));

      // commit
      drive(REQ_COMMIT, 8'd0, 32'd0);
      @(negedge clk);
`ifdef SPRITE_TABLE_DOUBLE_BUFFER_EN
      check("cm_pend", 32'(sw_if.to_sw_sig), 32'(RSP_PEND));
      repeat (3) @(negedge clk);
      check("cm_pend2", 32'(sw_if.to_sw_sig), 32'(RSP_PEND));
      check("cm_nofc", 32'(frame_commit), 32'd0);
      check("cm_e3_old", ent(3), 32'd0);
      pulse_frame();
      for (int i = 0; i < NS; i++) act_m[i] = pend_m[i];
      check("cm_fc", 32'(frame_commit), 32'd1);
      check("cm_rsp", 32'(sw_if.to_sw_sig), 32'(RSP_ACK));
      check_bank("cm");
      @(negedge clk);
      check("cm_fc_fall", 32'(frame_commit), 32'd0);
      check("cm_rsp_hold", 32'(sw_if.to_sw_sig), 32'(RSP_ACK));
`else
      check("cm_rsp", 32'(sw_if.to_sw_sig), 32'(RSP_ACK));
      check("cm_fc", 32'(frame_commit), 32'd0);
      check_bank("cm");
`endif
      drive(REQ_IDLE, 8'd0, 32'd0);
      @(negedge clk);
      check("cm_rel", 32'(sw_if.to_sw_sig), 32'(RSP_READY));

      // out-of-range index, then a nonzero request that ERR must ignore
      drive(REQ_WRITE, 8'd16, 32'h0000_03FF);
      @(negedge clk);
      check("err_rsp", 32'(sw_if.to_sw_sig), 32'(RSP_ERR));
      check("err_fc", 32'(frame_commit), 32'd0);
      drive(REQ_WRITE, 8'd4, e15);
      @(negedge clk);
      check("err_hold", 32'(sw_if.to_sw_sig), 32'(RSP_ERR));
      check_bank("err");
      drive(REQ_IDLE, 8'd0, 32'd0);
      @(negedge clk);
      check("err_rel", 32'(sw_if.to_sw_sig), 32'(RSP_READY));

      // highest legal index
      drive(REQ_WRITE, 8'd15, e15);
      @(negedge clk);
`ifdef SPRITE_TABLE_DOUBLE_BUFFER_EN
      pend_m[15] = e15;
`else
      act_m[15] = e15;
`endif
      check("wr15_rsp", 32'(sw_if.to_sw_sig), 32'(RSP_ACK));
      check("wr15_e15", ent(15), act_m[15]);
      drive(REQ_IDLE, 8'd0, 32'd0);
      @(negedge clk);

`ifdef SPRITE_TABLE_DOUBLE_BUFFER_EN
      // aborted commit
      drive(REQ_COMMIT, 8'd0, 32'd0);
      @(negedge clk);
      check("ab_pend", 32'(sw_if.to_sw_sig), 32'(RSP_PEND));
      @(negedge clk);
      drive(REQ_IDLE, 8'd0, 32'd0);
      @(negedge clk);
      check("ab_rsp", 32'(sw_if.to_sw_sig), 32'(RSP_READY));
      check("ab_fc", 32'(frame_commit), 32'd0);
`endif
      // frame_start while idle is ignored
      pulse_frame();
      check("idle_fs_fc", 32'(frame_commit), 32'd0);
      check_bank("idle_fs");

`ifdef SPRITE_TABLE_DOUBLE_BUFFER_EN
      // frame_start in the same cycle as the commit request is not used
      drive(REQ_COMMIT, 8'd0, 32'd0);
      pulse_frame();
      check("same_pend", 32'(sw_if.to_sw_sig), 32'(RSP_PEND));
      check("same_fc", 32'(frame_commit), 32'd0);
      check("same_e15", ent(15), 32'd0);
      repeat (2) @(negedge clk);
      pulse_frame();
      for (int i = 0; i < NS; i++) act_m[i] = pend_m[i];
      check("same_fc2", 32'(frame_commit), 32'd1);
      check_bank("same");
      drive(REQ_IDLE, 8'd0, 32'd0);
      @(negedge clk);
`endif

      // clear
      drive(REQ_CLEAR, 8'd0, 32'd0);
      @(negedge clk);
`ifdef SPRITE_TABLE_DOUBLE_BUFFER_EN
      for (int i = 0; i < NS; i++) pend_m[i] = '0;
      check("clr_fc", 32'(frame_commit), 32'd0);
`else
      for (int i = 0; i < NS; i++) act_m[i] = '0;
      check("clr_fc", 32'(frame_commit), 32'd1);
`endif
      check("clr_rsp", 32'(sw_if.to_sw_sig), 32'(RSP_ACK));
      check_bank("clr");
      drive(REQ_IDLE, 8'd0, 32'd0);
      @(negedge clk);
      drive(REQ_COMMIT, 8'd0, 32'd0);
      @(negedge clk);
`ifdef SPRITE_TABLE_DOUBLE_BUFFER_EN
      pulse_frame();
      for (int i = 0; i < NS; i++) act_m[i] = pend_m[i];
      check("clrcm_fc", 32'(frame_commit), 32'd1);
`endif
      check("clrcm_rsp", 32'(sw_if.to_sw_sig), 32'(RSP_ACK));
      check_bank("clrcm");
      check("clrcm_or", 32'(|{sprite_x, sprite_y, sprite_state, sprite_type}), 32'd0);
      drive(REQ_IDLE, 8'd0, 32'd0);
      @(negedge clk);

      // write entry 0, then reset in the middle of a transaction
      drive(REQ_WRITE, 8'd0, e0);
      @(negedge clk);
`ifdef SPRITE_TABLE_DOUBLE_BUFFER_EN
      pend_m[0] = e0;
      check("w0_e0", ent(0), 32'd0);
      drive(REQ_IDLE, 8'd0, 32'd0);
      @(negedge clk);
      drive(REQ_COMMIT, 8'd0, 32'd0);
      @(negedge clk);
      check("rw_pend", 32'(sw_if.to_sw_sig), 32'(RSP_PEND));
`else
      act_m[0] = e0;
      check("w0_e0", ent(0), e0);
      check("w0_fc", 32'(frame_commit), 32'd1);
`endif
      reset = 1'b1;
      @(negedge clk);
      for (int i = 0; i < NS; i++) act_m[i] = '0;
`ifdef SPRITE_TABLE_DOUBLE_BUFFER_EN
      for (int i = 0; i < NS; i++) pend_m[i] = '0;
`endif
      check("mrst_rsp", 32'(sw_if.to_sw_sig), 32'(RSP_READY));
      check("mrst_fc", 32'(frame_commit), 32'd0);
      check_bank("mrst");
      reset = 1'b0;
      drive(REQ_IDLE, 8'd0, 32'd0);
      @(negedge clk);
`ifdef SPRITE_TABLE_DOUBLE_BUFFER_EN
      // pending bank must also have been zeroed by reset
      drive(REQ_COMMIT, 8'd0, 32'd0);
      @(negedge clk);
      pulse_frame();
      check("post_fc", 32'(frame_commit), 32'd1);
      check_bank("post");
      drive(REQ_IDLE, 8'd0, 32'd0);
      @(negedge clk);
`endif
      check("end_rsp", 32'(sw_if.to_sw_sig), 32'(RSP_READY));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/sprite_table_comm.md
# sprite_table_comm

Parametrised software-to-hardware sprite table that replaces the fixed 16-port, one-register-per-port sprite exchange between the NIOS system and `frame_displayer`. Software writes sprite entries one at a time over a single 32-bit data port using a four-phase handshake on `to_hw_sig`/`to_sw_sig`. Entries accumulate in a pending bank and are copied to the active bank, which feeds the displayer, only at a frame boundary. This removes mid-frame tearing and per-sprite PIO ports.

## Interface
- `NUM_SPRITES`, 16: table depth; legal range 1..256.
- `X_W`, 10: x coordinate field width.
- `Y_W`, 10: y coordinate field width.
- `STATE_W`, 3: sprite state field width; value 0 means inactive.
- `TYPE_W`, 3: sprite type field width.
- Constraint: X_W+Y_W+STATE_W+TYPE_W ≤ 32.

Ports:
- `clk` in 1: system clock (CLOCK_50).
- `reset` in 1: reset; one clock; reset is synchronous and active-high.
- `to_hw_sig` in 2: request code from software. 00 idle, 01 write entry, 10 commit, 11 clear.
- `sw_index` in 8: entry index for a write.
- `sw_data` in 32: packed entry, LSB upward: x, y, state, type; upper bits ignored.
- `frame_start` in 1: one-cycle pulse at start of vertical blank.
- `to_sw_sig` out 2: response. 00 ready, 01 ack, 10 commit pending, 11 error.
- `sprite_x` out NUM_SPRITES*X_W: active bank x fields, entry i at [i*X_W +: X_W].
- `sprite_y` out NUM_SPRITES*Y_W: active bank y fields.
- `sprite_state` out NUM_SPRITES*STATE_W: active bank state fields.
- `sprite_type` out NUM_SPRITES*TYPE_W: active bank type fields.
- `frame_commit` out 1: one-cycle pulse on the edge that loads the active bank.

## Operation
- FSM states: IDLE, WAIT_FRAME, ACK, ERR.
- IDLE, `to_sw_sig`=00:
  - 01 with `sw_index` < NUM_SPRITES: write the pending entry on this edge, go to ACK.
  - 01 with `sw_index` ≥ NUM_SPRITES: no write, go to ERR.
  - 10: go to WAIT_FRAME.
  - 11: zero every pending entry (all fields), go to ACK.
- WAIT_FRAME, `to_sw_sig`=10:
  - On `frame_start`=1, copy pending to active, pulse `frame_commit`, go to ACK.
  - If `to_hw_sig` returns to 00 first, abort: no copy, go to IDLE.
- ACK, `to_sw_sig`=01: hold until `to_hw_sig`=00, then IDLE.
- ERR, `to_sw_sig`=11: hold until `to_hw_sig`=00, then IDLE.
- In ACK or ERR, a nonzero `to_hw_sig` is ignored. Software must return to 00 before issuing the next request.
- `frame_start` outside WAIT_FRAME: ignored.
- `frame_start` in the same cycle that IDLE sees a commit request: not used; the commit waits for the next `frame_start`.
- Clear affects only the pending bank. The active bank changes only through a commit.
- Reset, including mid-operation: both banks zero, FSM to IDLE, `to_sw_sig`=00, `frame_commit`=0. All sprite outputs read 0.

## Timing
- All outputs are registered.
- Write/clear: request seen at edge N → pending bank updated and `to_sw_sig`=01 after edge N.
- Commit: `frame_start` high at edge M → active outputs updated, `frame_commit`=1 and `to_sw_sig`=01 after edge M. `frame_commit` falls after edge M+1.
- Release: `to_hw_sig`=00 seen at edge K while in ACK/ERR → `to_sw_sig`=00 after edge K.
- Minimum full transaction for write or clear: 2 edges.

## Configuration
- `SPRITE_TABLE_DOUBLE_BUFFER_EN` defined: behaviour exactly as above.
- Not defined:
  - No pending bank; writes and clear act directly on the active bank.
  - `frame_commit` pulses on each write/clear edge.
  - Commit goes straight from IDLE to ACK without waiting for `frame_start`. WAIT_FRAME is unreachable.

## Structure
- `sprite_comm_pkg`:
  - handshake code constants: REQ_IDLE/WRITE/COMMIT/CLEAR, RSP_READY/ACK/PEND/ERR.
  - FSM state enum.
  - default field widths.
  - field-offset localparams derived from the widths.
- Sub-module `sprite_entry_bank`: one entry's pending and active registers, with write, clear and commit enables. Generated NUM_SPRITES times. The top holds the FSM and index decode.

## Test plan
- Reset, then write idx 3 with x=0x12C, y=0x0F0, state=2, type=5 via 01 → `to_sw_sig`=01 after 1 edge. Active entry 3 still 0.
- Then commit: `to_sw_sig`=10 until `frame_start`. Then entry 3 active = (0x12C, 0x0F0, 2, 5), `frame_commit` pulses exactly once, `to_sw_sig`=01; release → 00.
- Write with `sw_index`=16 (NUM_SPRITES=16) → `to_sw_sig`=11, no entry changes; release → 00.
- Commit requested, then `to_hw_sig` dropped to 00 before any `frame_start` → IDLE, active bank unchanged, no `frame_commit`.
- Clear, then commit → all active fields 0. Assert `reset` while in WAIT_FRAME → all outputs 0 on the next edge.
- Macro undefined: write idx 0 → active entry 0 updated one edge later with no `frame_start` applied.
